// File: rtl/htif_host_pkg.sv
// Shared constants and types for the HTIF host responder.
package htif_host_pkg;

   localparam logic [7:0] HTIF_DEV_CONSOLE = 8'd1;
   localparam logic [7:0] HTIF_CMD_PUTCHAR = 8'd1;

   localparam logic [1:0] REG_TOHOST_LO   = 2'd0;
   localparam logic [1:0] REG_TOHOST_HI   = 2'd1;
   localparam logic [1:0] REG_FROMHOST_LO = 2'd2;
   localparam logic [1:0] REG_FROMHOST_HI = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESP,
      ST_WAITQ,
      ST_HALT
   } htif_state_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] result;
      for (int i = 0; i < 4; i++) begin
         result[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/htif_host_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; a pop frees space for a same-cycle push.
module htif_host_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = storage[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clock) begin
      if (push_ok) storage[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/htif_host.sv
// HTIF device-side responder: tohost/fromhost registers, command decode, console byte stream.
module htif_host
   import htif_host_pkg::*;
#(
   parameter int fifo_depth = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        exit_valid,
   output logic [30:0] exit_code,
   output logic        err_valid
);

   htif_state_t state, state_next;

   logic [31:0] tohost_lo, tohost_hi, fromhost_lo, fromhost_hi;
   logic [31:0] rdata_q;
   logic [31:0] cur_reg, wr_merged, cmd_lo;
   logic [1:0]  sel;
   logic        is_write, is_command, is_putchar;
   logic        fifo_full, fifo_empty, fifo_pop, fifo_space;
   logic        req_fire, do_write, do_exit, do_putc, do_err;
   logic        unused_addr;

   assign sel         = mem_addr[3:2];
   assign unused_addr = ^{mem_addr[31:4], mem_addr[1:0]};
   assign is_write    = (mem_wstrb != 4'd0) && !mem_instr;
   assign req_fire    = mem_valid && ((state == ST_IDLE) || (state == ST_HALT));

   always_comb begin
      cur_reg = tohost_lo;
      case (sel)
         REG_TOHOST_LO:   cur_reg = tohost_lo;
         REG_TOHOST_HI:   cur_reg = tohost_hi;
         REG_FROMHOST_LO: cur_reg = fromhost_lo;
         REG_FROMHOST_HI: cur_reg = fromhost_hi;
         default:         cur_reg = tohost_lo;
      endcase
   end

   assign wr_merged  = merge_bytes(cur_reg, mem_wdata, mem_wstrb);
   assign is_command = is_write && (sel == REG_TOHOST_LO) && (wr_merged != 32'd0);
   // In WAITQ the command word has already landed in tohost_lo.
   assign cmd_lo     = (state == ST_WAITQ) ? tohost_lo : wr_merged;
   assign is_putchar = (tohost_hi[31:24] == HTIF_DEV_CONSOLE) && (tohost_hi[23:16] == HTIF_CMD_PUTCHAR);

   assign fifo_pop   = tx_valid && tx_ready;
   assign fifo_space = !fifo_full || fifo_pop;

   always_comb begin
      // NOTE: defaults come first so every path assigns everything and no latch is inferred.
      state_next = state;
      do_write   = 1'b0;
      do_exit    = 1'b0;
      do_putc    = 1'b0;
      do_err     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_fire) begin
               do_write   = is_write;
               state_next = ST_RESP;
               if (is_command) begin
                  if (cmd_lo[0]) begin
                     do_exit = 1'b1;
                  end else if (is_putchar) begin
                     if (fifo_space) do_putc = 1'b1;
                     else            state_next = ST_WAITQ;
                  end else begin
                     do_err = 1'b1;
                  end
               end
            end
         end
         ST_HALT: begin
            if (req_fire) begin
               do_write   = is_write;
               state_next = ST_RESP;
            end
         end
         ST_WAITQ: begin
            if (fifo_space) begin
               do_putc    = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            state_next = exit_valid ? ST_HALT : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tohost_lo   <= '0;
         tohost_hi   <= '0;
         fromhost_lo <= '0;
         fromhost_hi <= '0;
         rdata_q     <= '0;
         exit_valid  <= 1'b0;
         exit_code   <= '0;
         err_valid   <= 1'b0;
      end else begin
         err_valid <= do_err;
         if (req_fire) rdata_q <= mem_instr ? 32'd0 : cur_reg;
         if (do_write) begin
            case (sel)
               REG_TOHOST_LO:   tohost_lo   <= wr_merged;
               REG_TOHOST_HI:   tohost_hi   <= wr_merged;
               REG_FROMHOST_LO: fromhost_lo <= wr_merged;
               REG_FROMHOST_HI: fromhost_hi <= wr_merged;
               default: ;
            endcase
         end
         // Command side effects come last so they override the raw register write.
         if (do_exit) begin
            exit_code  <= cmd_lo[31:1];
            exit_valid <= 1'b1;
         end
         if (do_putc) begin
            fromhost_hi <= {tohost_hi[31:16], 16'h0};
            fromhost_lo <= 32'd1;
         end
         if (do_exit || do_putc || do_err) begin
            tohost_lo <= '0;
            tohost_hi <= '0;
         end
      end
   end

   assign mem_ready = (state == ST_RESP);
   assign mem_rdata = mem_ready ? rdata_q : 32'd0;
   assign tx_valid  = !fifo_empty;

   htif_host_fifo #(
      .WIDTH(8),
      .DEPTH(fifo_depth)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (do_putc),
      .push_data (cmd_lo[7:0]),
      .pop       (fifo_pop),
      .pop_data  (tx_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_htif_host.sv
// Directed self-checking bench for htif_host: bus access, putchar, FIFO stall, exit, error, reset.
module tb_htif_host;

   logic        clock;
   logic        reset;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        exit_valid;
   logic [30:0] exit_code;
   logic        err_valid;

   int          vectors    = 0;
   int          miscompares = 0;
   logic [31:0] last_rdata;
   int          last_waits;
   logic        last_err;
   logic [7:0]  popped;
   logic        ready_seen;

   htif_host #(.fifo_depth(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .mem_valid  (mem_valid),
      .mem_instr  (mem_instr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .exit_valid (exit_valid),
      .exit_code  (exit_code),
      .err_valid  (err_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $fatal(1, "FAIL watchdog: simulation did not finish");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Issues one request and waits (bounded) for its completion pulse.
   task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr);
      @(negedge clock);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      mem_instr = instr;
      @(negedge clock);
      mem_valid = 1'b0;
      mem_wstrb = 4'd0;
      mem_instr = 1'b0;
      last_waits = 0;
      while (!mem_ready && last_waits < 40) begin
         @(negedge clock);
         last_waits++;
      end
      if (!mem_ready) check("bus_timeout", 32'(mem_ready), 32'd1);
      last_rdata = mem_rdata;
      last_err   = err_valid;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      access(addr, data, 4'hF, 1'b0);
   endtask

   task automatic rd(input logic [31:0] addr);
      access(addr, 32'd0, 4'h0, 1'b0);
   endtask

   task automatic putchar(input logic [7:0] b);
      wr(32'h4, 32'h0101_0000);
      wr(32'h0, {24'd0, b});
   endtask

   task automatic pop_byte();
      @(negedge clock);
      check("pop_tx_valid", 32'(tx_valid), 32'd1);
      popped   = tx_data;
      tx_ready = 1'b1;
      @(negedge clock);
      tx_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      tx_ready  = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // 1. reset state and a plain read
      @(negedge clock);
      check("rst_mem_ready", 32'(mem_ready), 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_exit_valid", 32'(exit_valid), 32'd0);
      check("rst_exit_code", 32'(exit_code), 32'd0);
      check("rst_err_valid", 32'(err_valid), 32'd0);
      rd(32'h8);
      check("read_latency", 32'(last_waits), 32'd0);
      check("read_fromhost_lo_rst", last_rdata, 32'd0);

      // 2. single putchar
      wr(32'h4, 32'h0101_0000);
      wr(32'h0, 32'h0000_0042);
      check("putc_latency", 32'(last_waits), 32'd0);
      @(negedge clock);
      check("ready_one_cycle", 32'(mem_ready), 32'd0);
      check("putc_tx_valid", 32'(tx_valid), 32'd1);
      check("putc_tx_data", 32'(tx_data), 32'h42);
      rd(32'h8);
      check("putc_fromhost_lo", last_rdata, 32'd1);
      rd(32'hC);
      check("putc_fromhost_hi", last_rdata, 32'h0101_0000);
      rd(32'h0);
      check("putc_tohost_lo", last_rdata, 32'd0);
      rd(32'h4);
      check("putc_tohost_hi", last_rdata, 32'd0);
      access(32'h8, 32'hAABB_CCDD, 4'b0010, 1'b0);
      access(32'h8, 32'd0, 4'h0, 1'b1);
      check("fetch_reads_zero", last_rdata, 32'd0);
      rd(32'h8);
      check("wstrb_merge", last_rdata, 32'h0000_CC01);
      wr(32'h8, 32'd0);
      rd(32'h8);
      check("fromhost_clear", last_rdata, 32'd0);
      pop_byte();
      check("putc_popped", 32'(popped), 32'h42);
      @(negedge clock);
      check("putc_drained", 32'(tx_valid), 32'd0);

      // 3. fill the FIFO, ninth putchar stalls in WAITQ
      for (int i = 0; i < 8; i++) putchar(8'h30 + 8'(2 * i));
      wr(32'h4, 32'h0101_0000);
      @(negedge clock);
      mem_valid = 1'b1;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0000_0040;
      mem_wstrb = 4'hF;
      @(negedge clock);
      mem_valid  = 1'b0;
      mem_wstrb  = 4'h0;
      ready_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mem_ready) ready_seen = 1'b1;
         @(negedge clock);
      end
      check("waitq_stall", 32'(ready_seen), 32'd0);
      check("full_head", 32'(tx_data), 32'h30);
      tx_ready = 1'b1;
      @(negedge clock);
      tx_ready = 1'b0;
      check("waitq_release", 32'(mem_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         pop_byte();
         check($sformatf("order_%0d", i), 32'(popped), 32'h32 + 32'(2 * i));
      end
      @(negedge clock);
      check("order_drained", 32'(tx_valid), 32'd0);

      // 4. exit command, HALT behaviour
      wr(32'h0, 32'h0000_0007);
      check("exit_valid", 32'(exit_valid), 32'd1);
      check("exit_code", 32'(exit_code), 32'd3);
      putchar(8'h44);
      check("halt_access_done", 32'(last_waits), 32'd0);
      @(negedge clock);
      check("halt_no_putc", 32'(tx_valid), 32'd0);
      rd(32'h0);
      check("halt_write_lands", last_rdata, 32'h0000_0044);
      check("halt_exit_sticky", 32'(exit_valid), 32'd1);
      check("halt_exit_code", 32'(exit_code), 32'd3);

      // 5. unsupported command
      do_reset();
      @(negedge clock);
      check("rst2_exit_valid", 32'(exit_valid), 32'd0);
      putchar(8'h54);
      wr(32'h4, 32'h0200_0000);
      wr(32'h0, 32'h0000_0010);
      check("err_pulse", 32'(last_err), 32'd1);
      @(negedge clock);
      check("err_one_cycle", 32'(err_valid), 32'd0);
      rd(32'h0);
      check("err_tohost_lo", last_rdata, 32'd0);
      rd(32'h4);
      check("err_tohost_hi", last_rdata, 32'd0);
      rd(32'h8);
      check("err_fromhost_kept", last_rdata, 32'd1);
      pop_byte();
      check("err_fifo_head", 32'(popped), 32'h54);
      @(negedge clock);
      check("err_fifo_one", 32'(tx_valid), 32'd0);

      // 6. reset while stalled in WAITQ
      for (int i = 0; i < 8; i++) putchar(8'h60 + 8'(2 * i));
      wr(32'h4, 32'h0101_0000);
      @(negedge clock);
      mem_valid = 1'b1;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0000_0070;
      mem_wstrb = 4'hF;
      @(negedge clock);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      @(negedge clock);
      check("pre_reset_stall", 32'(mem_ready), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      check("reset_no_ready", 32'(mem_ready), 32'd0);
      check("reset_fifo_flush", 32'(tx_valid), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("post_reset_no_ready", 32'(mem_ready), 32'd0);
      rd(32'h8);
      check("post_reset_idle", 32'(last_waits), 32'd0);
      check("post_reset_regs", last_rdata, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
